// File: rtl/tape_mem_arbiter.sv
// Two-port arbiter for the single SDRAM byte-read channel: cassette fetch (port 0) and host
// reads (port 1). One outstanding read at a time, round-robin or port-0 fixed priority.
module tape_mem_arbiter #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              valid0_o,
  output logic              valid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                valid0_q, valid0_d, valid1_q, valid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                winner;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    winner     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          // On a tie round-robin favours the port that did not win last time.
          if (req0_i && req1_i) winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
          else                  winner = req1_i;
          sel_d      = winner;
          last_d     = winner;
          mem_addr_d = winner ? addr1_i : addr0_i;
          mem_rd_d   = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (mem_ready_i) begin
          mem_rd_d = 1'b0;
          gnt0_d   = ~sel_q;
          gnt1_d   = sel_q;
          cnt_d    = CntW'(LATENCY - 1);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (sel_q) begin
            rdata1_d = mem_rdata_i;
            valid1_d = 1'b1;
          end else begin
            rdata0_d = mem_rdata_i;
            valid0_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign valid0_o   = valid0_q;
  assign valid1_o   = valid1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign busy_o     = busy_q;

endmodule
